modulus_counter: RTL and testbench

- Synchronous modulo-MAX up-counter: counts 0, 1, …, MAX-1, then wraps to 0.
- Counts only while its active-low enable is asserted.
- General-purpose timebase/divider block; its terminal-count flag can cascade counters or strobe downstream logic.
- Single clock domain; no CDC inside.

---
 rtl/modulus_counter.sv | 60 ++++++
 tb/tb_modulus_counter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/modulus_counter.sv
// Synchronous modulo-MAX up-counter with active-low enable and terminal-count flag.
// Optional parallel load is compiled in with `define MODULUS_COUNTER_LOAD_EN.
module modulus_counter #(
  parameter  int MAX = 53,
  localparam int W   = $clog2(MAX)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable_n,
`ifdef MODULUS_COUNTER_LOAD_EN
  input  logic         load_n,
  input  logic [W-1:0] din,
`endif
  output logic [W-1:0] Q,
  output logic         tc
);

  if (MAX < 2) begin : g_bad_max
    $error("modulus_counter: MAX must be >= 2");
  end

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] q_p0;
  logic [W-1:0] q_nxt;
  logic         at_last;

  assign at_last = (q_p0 == LAST);

  always_comb begin
    q_nxt = q_p0;
    if (!enable_n) begin
      q_nxt = at_last ? '0 : q_p0 + W'(1);
    end
`ifdef MODULUS_COUNTER_LOAD_EN
    // Out-of-range load values collapse to 0 so Q never leaves [0, MAX-1].
    if (!load_n) begin
      q_nxt = ({1'b0, din} < (W + 1)'(MAX)) ? din : '0;
    end
`endif
  end

  // Stage p0: count register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_p0 <= '0;
    end else begin
      q_p0 <= q_nxt;
    end
  end

  assign Q = q_p0;

`ifdef MODULUS_COUNTER_LOAD_EN
  assign tc = at_last && !enable_n && load_n;
`else
  assign tc = at_last && !enable_n;
`endif

endmodule

// File: tb/tb_modulus_counter.sv
// Scoreboard bench for modulus_counter (default MAX=53); load tests run only when
// MODULUS_COUNTER_LOAD_EN is defined.
module tb_modulus_counter;

  localparam int MAX = 53;
  localparam int W   = $clog2(MAX);

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         enable_n = 1'b1;
  logic         load_n = 1'b1;
  logic [W-1:0] din = '0;
  logic [W-1:0] Q;
  logic         tc;

  modulus_counter #(.MAX(MAX)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable_n (enable_n),
`ifdef MODULUS_COUNTER_LOAD_EN
    .load_n   (load_n),
    .din      (din),
`endif
    .Q        (Q),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_bad   = 0;
  int          tc_seen = 0;
  int          m       = 0;
  bit          mv      = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check tc before the edge, check Q after it.
  task automatic step(input logic rn, input logic en, input logic ln, input int d);
    int          nxt;
    logic [31:0] e;
    reset_n  = rn;
    enable_n = en;
    load_n   = ln;
    din      = d[W-1:0];
    #3;
    if (mv) begin
      check_val("tc", {31'b0, tc}, {31'b0, (m == MAX - 1) && !en && ln});
      if (tc === 1'b1) tc_seen++;
    end
    if (!rn)               nxt = 0;
    else if (!ln)          nxt = (d < MAX) ? d : 0;
    else if (!en)          nxt = (m == MAX - 1) ? 0 : m + 1;
    else                   nxt = m;
    if (!rn) mv = 1'b1;
    m = nxt;
    if (mv) exp_q.push_back(nxt);
    @(posedge clk);
    #1;
    if (mv) begin
      e = exp_q.pop_front();
      check_val("q", {{(32-W){1'b0}}, Q}, e);
    end
  endtask

  task automatic steps(input int n, input logic en);
    for (int i = 0; i < n; i++) step(1'b1, en, 1'b1, 0);
  endtask

  // Low pulse on reset_n that sits entirely between two rising edges.
  task automatic glitch_reset();
    logic [31:0] e;
    #2 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("q_glitch", {{(32-W){1'b0}}, Q}, e);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with enable off, then hold at 0
    step(1'b0, 1'b1, 1'b1, 0);
    check_val("tc_reset", {31'b0, tc}, 32'd0);
    steps(20, 1'b1);

    // Short reset pulse between edges leaves Q alone
    steps(7, 1'b0);
    enable_n = 1'b1;
    glitch_reset();
    steps(1, 1'b1);

    // Full count and wrap, two tc pulses over 106 cycles
    step(1'b0, 1'b1, 1'b1, 0);
    tc_seen = 0;
    steps(106, 1'b0);
    check_val("tc_pulses", tc_seen, 32'd2);

    // Hold at last value keeps tc low
    steps(MAX - 1, 1'b0);
    steps(3, 1'b1);
    steps(1, 1'b0);

    // Hold at 10 then resume
    step(1'b0, 1'b1, 1'b1, 0);
    steps(10, 1'b0);
    steps(5, 1'b1);
    steps(1, 1'b0);

    // Reset mid-count at 30
    step(1'b0, 1'b1, 1'b1, 0);
    steps(30, 1'b0);
    step(1'b0, 1'b0, 1'b1, 0);
    steps(1, 1'b0);

`ifdef MODULUS_COUNTER_LOAD_EN
    step(1'b1, 1'b1, 1'b0, 50);
    steps(3, 1'b0);
    step(1'b1, 1'b1, 1'b0, 60);
    step(1'b1, 1'b1, 1'b0, 52);
    step(1'b1, 1'b0, 1'b0, 5);
    step(1'b1, 1'b0, 1'b0, 63);
    step(1'b1, 1'b1, 1'b0, 20);
    step(1'b0, 1'b0, 1'b0, 50);
    steps(2, 1'b0);
`endif

    check_val("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
